// File: rtl/keypad_scan_decoder_pkg.sv
// Shared definitions for the 4x4 keypad scanner: state codes, idle column
// pattern and key-index packing used by the game FSM.
package kb_pkg;

    localparam logic [2:0] KB_ST_IDLE     = 3'd0;
    localparam logic [2:0] KB_ST_DRIVE    = 3'd1;
    localparam logic [2:0] KB_ST_SAMPLE   = 3'd2;
    localparam logic [2:0] KB_ST_DEBOUNCE = 3'd3;
    localparam logic [2:0] KB_ST_PRESSED  = 3'd4;
    localparam logic [2:0] KB_ST_RELEASE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = KB_ST_IDLE,
        ST_DRIVE    = KB_ST_DRIVE,
        ST_SAMPLE   = KB_ST_SAMPLE,
        ST_DEBOUNCE = KB_ST_DEBOUNCE,
        ST_PRESSED  = KB_ST_PRESSED,
        ST_RELEASE  = KB_ST_RELEASE
    } kb_state_t;

    localparam logic [3:0] KB_COLS_IDLE = 4'b1111;

    // Index bit 3 selects x (rows 2-3) vs y (rows 0-1) downstream.
    localparam int KB_X_FLAG_BIT = 3;

    function automatic logic [3:0] kb_pack_index(input logic [1:0] row,
                                                 input logic [1:0] col);
        logic [3:0] idx;
        idx = 4'd0;
        idx[KB_X_FLAG_BIT -: 2] = row;
        idx[1:0] = col;
        return idx;
    endfunction

    function automatic logic [3:0] kb_col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: drives columns, debounces rows, and hands one
// key index per physical press to the game FSM over valid/ready.
//
// state    | meaning
// IDLE     | scanner disabled, no column driven
// DRIVE    | column col_idx driven, one tick of settle time
// SAMPLE   | rows checked on tick; hit starts debounce, miss advances column
// DEBOUNCE | counting ticks with cand_row held low
// PRESSED  | key_valid high, waiting for key_ready
// RELEASE  | waiting for all rows high for DEBOUNCE_TICKS ticks
module keypad_scan_decoder
    import kb_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic       en,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic [3:0] pressed_index,
    output logic       key_valid,
    input  logic       key_ready
);

    localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_TICKS);

    kb_state_t        state;
    logic [1:0]       col_idx;
    logic [1:0]       cand_row;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic [3:0]       row_s;
    logic [1:0]       hit_row;
    logic [1:0]       col_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rcnt_inc;
    logic             any_low;
    logic             cand_low;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (keyboard_row),
        .q   (row_s)
    );

    // Lowest-numbered low row wins when several rows are pulled down.
    always_comb begin
        hit_row = 2'd3;
        if (!row_s[0])
            hit_row = 2'd0;
        else if (!row_s[1])
            hit_row = 2'd1;
        else if (!row_s[2])
            hit_row = 2'd2;
    end

    assign any_low  = ~&row_s;
    assign cand_low = ~row_s[cand_row];
    assign col_next = col_idx + 2'd1;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign rcnt_inc = rcnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state         <= ST_IDLE;
            keyboard_col  <= KB_COLS_IDLE;
            key_valid     <= 1'b0;
            pressed_index <= 4'd0;
            col_idx       <= 2'd0;
            cand_row      <= 2'd0;
            cnt           <= '0;
            rcnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    col_idx      <= 2'd0;
                    keyboard_col <= kb_col_drive(2'd0);
                    state        <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (scan_tick)
                        state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (scan_tick) begin
                        if (!any_low) begin
                            col_idx      <= col_next;
                            keyboard_col <= kb_col_drive(col_next);
                            state        <= ST_DRIVE;
                        end else begin
                            cand_row <= hit_row;
                            if (DB_TC == CNT_W'(1)) begin
                                pressed_index <= kb_pack_index(hit_row, col_idx);
                                key_valid     <= 1'b1;
                                cnt           <= '0;
                                state         <= ST_PRESSED;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_tick) begin
                        if (cand_low) begin
                            if (cnt_inc == DB_TC) begin
                                pressed_index <= kb_pack_index(cand_row, col_idx);
                                key_valid     <= 1'b1;
                                cnt           <= '0;
                                state         <= ST_PRESSED;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt          <= '0;
                            col_idx      <= col_next;
                            keyboard_col <= kb_col_drive(col_next);
                            state        <= ST_DRIVE;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        rcnt      <= '0;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Column stays driven so a held key keeps rcnt at zero.
                    if (scan_tick) begin
                        if (any_low) begin
                            rcnt <= '0;
                        end else if (rcnt_inc == DB_TC) begin
                            rcnt         <= '0;
                            col_idx      <= col_next;
                            keyboard_col <= kb_col_drive(col_next);
                            state        <= ST_DRIVE;
                        end else begin
                            rcnt <= rcnt_inc;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    keyboard_col <= KB_COLS_IDLE;
                    key_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a physical keypad model closes row/column
// contacts from a press mask; expectations come from scan-timing arithmetic.
module tb_keypad_scan_decoder;

    localparam int DT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_tick = 1'b0;
    logic        en = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  keyboard_row;
    logic [3:0]  keyboard_col;
    logic [3:0]  pressed_index;
    logic        key_valid;
    logic [15:0] press_mask = 16'd0;

    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    logic prev_valid = 1'b0;

    keypad_scan_decoder #(
        .DEBOUNCE_TICKS (DT),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scan_tick     (scan_tick),
        .en            (en),
        .keyboard_row  (keyboard_row),
        .keyboard_col  (keyboard_col),
        .pressed_index (pressed_index),
        .key_valid     (key_valid),
        .key_ready     (key_ready)
    );

    always #5 clk = ~clk;

    // Row r is pulled low when any pressed key in row r sits on a driven column.
    always_comb begin
        keyboard_row = 4'b1111;
        for (int r = 0; r < 4; r++)
            keyboard_row[r] = ~|(press_mask[r*4 +: 4] & ~keyboard_col);
    end

    always @(posedge clk) begin
        #2;
        if (key_valid && !prev_valid)
            pulses++;
        prev_valid = key_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic tick();
        repeat (7) @(negedge clk);
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    // Active-low one-hot drive pattern for column c.
    function automatic logic [3:0] col_exp(input int c);
        return 4'(15 - (1 << (c % 4)));
    endfunction

    initial begin
        int base;
        int r;
        int r2;
        int c;
        int d;

        // Reset
        repeat (3) clk1();
        chk("reset_col", keyboard_col, 4'b1111);
        chk("reset_valid", 4'(key_valid), 4'd0);
        chk("reset_idx", pressed_index, 4'd0);
        rst = 1'b0;
        clk1();
        chk("idle_col", keyboard_col, 4'b1111);

        // Free-running sweep, ready held high while nothing is valid
        key_ready = 1'b1;
        en = 1'b1;
        clk1();
        chk("sweep_start", keyboard_col, col_exp(0));
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk("sweep_col", keyboard_col, col_exp(n / 2));
            chk("sweep_valid", 4'(key_valid), 4'd0);
        end
        en = 1'b0;
        clk1();

        // Row1/col2 held, ready tied high: exactly one pulse, index 6
        base = pulses;
        press_mask = 16'(1 << 6);
        en = 1'b1;
        clk1();
        repeat (2 * 2 + DT) tick();
        chk("r1c2_early", 4'(pulses - base), 4'd0);
        tick();
        chk("r1c2_valid", 4'(key_valid), 4'd1);
        chk("r1c2_idx", pressed_index, 4'd6);
        repeat (6) tick();
        chk("r1c2_once", 4'(pulses - base), 4'd1);
        chk("r1c2_held_col", keyboard_col, col_exp(2));
        press_mask = 16'd0;
        repeat (DT) tick();
        chk("r1c2_resume", keyboard_col, col_exp(3));
        en = 1'b0;
        key_ready = 1'b0;
        clk1();

        // Bounce on row3/col0, then clean press row3/col3
        base = pulses;
        press_mask = 16'(1 << 12);
        en = 1'b1;
        clk1();
        repeat (3) tick();
        press_mask = 16'd0;
        tick();
        chk("bounce_col", keyboard_col, col_exp(1));
        chk("bounce_nokey", 4'(pulses - base), 4'd0);
        press_mask = 16'(1 << 15);
        repeat (2 * (3 - 1) + DT) tick();
        chk("r3c3_early", 4'(key_valid), 4'd0);
        tick();
        chk("r3c3_valid", 4'(key_valid), 4'd1);
        chk("r3c3_idx", pressed_index, 4'd15);

        // Ready withheld for 50 clocks
        for (int i = 0; i < 50; i++) begin
            clk1();
            chk("hold_valid", 4'(key_valid), 4'd1);
            chk("hold_idx", pressed_index, 4'd15);
            chk("hold_col", keyboard_col, col_exp(3));
        end
        key_ready = 1'b1;
        clk1();
        key_ready = 1'b0;
        chk("hs_drop", 4'(key_valid), 4'd0);
        press_mask = 16'd0;
        repeat (DT - 1) tick();
        chk("rel_wait_col", keyboard_col, col_exp(3));
        tick();
        chk("rel_resume", keyboard_col, col_exp(0));
        chk("r3c3_once", 4'(pulses - base), 4'd1);
        en = 1'b0;
        clk1();

        // Rows 0 and 2 on col1: lowest row wins
        base = pulses;
        press_mask = 16'((1 << 1) | (1 << 9));
        en = 1'b1;
        clk1();
        repeat (2 * 1 + DT) tick();
        chk("multi_early", 4'(key_valid), 4'd0);
        tick();
        chk("multi_valid", 4'(key_valid), 4'd1);
        chk("multi_idx", pressed_index, 4'd1);

        // en dropped in PRESSED
        en = 1'b0;
        clk1();
        chk("endrop_col", keyboard_col, 4'b1111);
        chk("endrop_valid", 4'(key_valid), 4'd0);
        press_mask = 16'd0;
        en = 1'b1;
        clk1();
        chk("reen_col", keyboard_col, col_exp(0));
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("reen_sweep", keyboard_col, col_exp(n / 2));
        end
        chk("reen_nostale", 4'(pulses - base), 4'd1);
        en = 1'b0;
        clk1();

        // rst pulsed mid-debounce
        base = pulses;
        press_mask = 16'(1 << 0);
        en = 1'b1;
        clk1();
        repeat (3) tick();
        rst = 1'b1;
        clk1();
        chk("rst_col", keyboard_col, 4'b1111);
        chk("rst_valid", 4'(key_valid), 4'd0);
        rst = 1'b0;
        press_mask = 16'd0;
        clk1();
        chk("rst_restart", keyboard_col, col_exp(0));
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("rst_sweep", keyboard_col, col_exp(n / 2));
        end
        chk("rst_nostale", 4'(pulses - base), 4'd0);
        en = 1'b0;
        clk1();

        // Randomized presses with random consumer delay
        for (int it = 0; it < 8; it++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            press_mask = 16'(1 << (r * 4 + c));
            if (r < 3 && $urandom_range(0, 1) == 1) begin
                r2 = int'($urandom_range(r + 1, 3));
                press_mask = press_mask | 16'(1 << (r2 * 4 + c));
            end
            base = pulses;
            en = 1'b1;
            clk1();
            repeat (2 * c + DT) tick();
            chk("rnd_early", 4'(key_valid), 4'd0);
            tick();
            chk("rnd_valid", 4'(key_valid), 4'd1);
            chk("rnd_idx", pressed_index, 4'(r * 4 + c));
            d = int'($urandom_range(0, 20));
            repeat (d) clk1();
            chk("rnd_hold", 4'(key_valid), 4'd1);
            chk("rnd_col", keyboard_col, col_exp(c));
            key_ready = 1'b1;
            clk1();
            key_ready = 1'b0;
            chk("rnd_drop", 4'(key_valid), 4'd0);
            press_mask = 16'd0;
            repeat (DT) tick();
            chk("rnd_resume", keyboard_col, col_exp(c + 1));
            repeat (8) tick();
            chk("rnd_once", 4'(pulses - base), 4'd1);
            en = 1'b0;
            clk1();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
